// File: rtl/sseg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : sseg_scan_decoder
// Purpose  : Watches a multiplexed 4-digit seven-segment drive (active-low
//            anodes plus active-low segment byte) and rebuilds the displayed
//            content. It decodes each stable digit to a symbol code,
//            assembles complete 4-digit frames and tracks the position and
//            step direction of a rotating square.
// Ports    : clk, rst_n        - clock, asynchronous active-low reset
//            an[3:0]           - anode select, bit i low selects digit i
//            sseg[7:0]         - segments {dp,g,f,e,d,c,b,a}, active-low
//            sym[19:0]         - symbol code per digit, digit i at [5i+4:5i]
//            dp[3:0]           - decimal point per digit, 1 = lit
//            sym_valid         - pulse per accepted digit
//            active_digit[1:0] - index of the last accepted digit
//            frame_valid       - pulse when all 4 digits updated since last frame
//            pos[2:0]          - last decoded square position
//            pos_valid         - pulse when pos updates
//            cw_step/ccw_step  - pulse on a +1 / -1 (mod 8) position move
//            jump              - pulse on any other position change
//            err               - pulse when an accepted anode has 2+ bits low
// Revision : 1.0 - initial release
// ============================================================================
module sseg_scan_decoder #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  an,
   input  logic [7:0]  sseg,
   output logic [19:0] sym,
   output logic [3:0]  dp,
   output logic        sym_valid,
   output logic [1:0]  active_digit,
   output logic        frame_valid,
   output logic [2:0]  pos,
   output logic        pos_valid,
   output logic        cw_step,
   output logic        ccw_step,
   output logic        jump,
   output logic        err
);

   localparam logic [7:0] CNT_ACCEPT = 8'(STABLE_CYCLES - 1);
   localparam logic [7:0] CNT_MAX    = 8'(STABLE_CYCLES);
   localparam logic [4:0] SYM_TOP    = 5'h10;
   localparam logic [4:0] SYM_BOTTOM = 5'h11;
   localparam logic [4:0] SYM_BLANK  = 5'h12;
   localparam logic [4:0] SYM_BAD    = 5'h1F;

   // 7-bit gfedcba pattern to symbol code
   function automatic logic [4:0] decode_sym(input logic [6:0] seg);
      logic [4:0] code;
      case (seg)
         7'h40:   code = 5'h00;
         7'h79:   code = 5'h01;
         7'h24:   code = 5'h02;
         7'h30:   code = 5'h03;
         7'h19:   code = 5'h04;
         7'h12:   code = 5'h05;
         7'h02:   code = 5'h06;
         7'h78:   code = 5'h07;
         7'h00:   code = 5'h08;
         7'h10:   code = 5'h09;
         7'h08:   code = 5'h0A;
         7'h03:   code = 5'h0B;
         7'h46:   code = 5'h0C;
         7'h21:   code = 5'h0D;
         7'h06:   code = 5'h0E;
         7'h0E:   code = 5'h0F;
         7'h1C:   code = SYM_TOP;
         7'h23:   code = SYM_BOTTOM;
         7'h7F:   code = SYM_BLANK;
         default: code = SYM_BAD;
      endcase
      return code;
   endfunction

   // Square walks clockwise: top row left-to-right is d0..d3 seen from the
   // wrap point, bottom row runs d0..d3 and the top returns d3..d1.
   function automatic logic [2:0] square_pos(input logic [1:0] digit, input logic bottom);
      logic [2:0] p;
      case ({digit, bottom})
         3'b00_0: p = 3'd0;
         3'b00_1: p = 3'd1;
         3'b01_1: p = 3'd2;
         3'b10_1: p = 3'd3;
         3'b11_1: p = 3'd4;
         3'b11_0: p = 3'd5;
         3'b10_0: p = 3'd6;
         default: p = 3'd7;   // d1 top
      endcase
      return p;
   endfunction

   logic [11:0] hold_q,        hold_d;
   logic [7:0]  cnt_q,         cnt_d;
   logic [19:0] sym_q,         sym_d;
   logic [3:0]  dp_q,          dp_d;
   logic        sym_valid_q,   sym_valid_d;
   logic [1:0]  active_q,      active_d;
   logic [3:0]  mask_q,        mask_d;
   logic        frame_valid_q, frame_valid_d;
   logic [2:0]  pos_q,         pos_d;
   logic        pos_valid_q,   pos_valid_d;
   logic        prev_valid_q,  prev_valid_d;
   logic        cw_q,          cw_d;
   logic        ccw_q,         ccw_d;
   logic        jump_q,        jump_d;
   logic        err_q,         err_d;

   logic        accept;
   logic        single;
   logic        multi;
   logic [1:0]  idx;
   logic [4:0]  code;
   logic [3:0]  mask_new;
   logic [2:0]  pos_new;
   logic [2:0]  delta;

   always_comb begin
      hold_d        = hold_q;
      cnt_d         = cnt_q;
      sym_d         = sym_q;
      dp_d          = dp_q;
      sym_valid_d   = 1'b0;
      active_d      = active_q;
      mask_d        = mask_q;
      frame_valid_d = 1'b0;
      pos_d         = pos_q;
      pos_valid_d   = 1'b0;
      prev_valid_d  = prev_valid_q;
      cw_d          = 1'b0;
      ccw_d         = 1'b0;
      jump_d        = 1'b0;
      err_d         = 1'b0;
      single        = 1'b0;
      multi         = 1'b0;
      idx           = 2'd0;
      mask_new      = mask_q;
      pos_new       = pos_q;
      delta         = 3'd0;

      // Stability filter; the counter saturates so a long run accepts once
      if ({an, sseg} != hold_q) begin
         hold_d = {an, sseg};
         cnt_d  = 8'd1;
      end else if (cnt_q < CNT_MAX) begin
         cnt_d  = cnt_q + 8'd1;
      end
      accept = ({an, sseg} == hold_q) && (cnt_q == CNT_ACCEPT);

      code = decode_sym(hold_q[6:0]);

      case (hold_q[11:8])
         4'b1110: begin single = 1'b1; idx = 2'd0; end
         4'b1101: begin single = 1'b1; idx = 2'd1; end
         4'b1011: begin single = 1'b1; idx = 2'd2; end
         4'b0111: begin single = 1'b1; idx = 2'd3; end
         4'b1111: ;                    // idle: nothing driven
         default: multi = 1'b1;
      endcase

      if (accept && single) begin
         for (int d = 0; d < 4; d++) begin
            if (idx == 2'(d)) begin
               sym_d[5*d +: 5] = code;
               dp_d[d]         = ~hold_q[7];
            end
         end
         sym_valid_d = 1'b1;
         active_d    = idx;
         mask_new    = mask_q | (4'b0001 << idx);
         if (mask_new == 4'hF) begin
            frame_valid_d = 1'b1;
            mask_d        = 4'h0;
         end else begin
            mask_d        = mask_new;
         end

         if ((code == SYM_TOP) || (code == SYM_BOTTOM)) begin
            pos_new      = square_pos(idx, code == SYM_BOTTOM);
            pos_d        = pos_new;
            pos_valid_d  = 1'b1;
            prev_valid_d = 1'b1;
            // 3-bit subtraction gives the move modulo 8
            delta        = pos_new - pos_q;
            if (prev_valid_q) begin
               case (delta)
                  3'd0:    ;
                  3'd1:    cw_d   = 1'b1;
                  3'd7:    ccw_d  = 1'b1;
                  default: jump_d = 1'b1;
               endcase
            end
         end
      end else if (accept && multi) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q        <= 12'hFFF;
         cnt_q         <= 8'd0;
         sym_q         <= {4{SYM_BLANK}};
         dp_q          <= 4'h0;
         sym_valid_q   <= 1'b0;
         active_q      <= 2'd0;
         mask_q        <= 4'h0;
         frame_valid_q <= 1'b0;
         pos_q         <= 3'd0;
         pos_valid_q   <= 1'b0;
         prev_valid_q  <= 1'b0;
         cw_q          <= 1'b0;
         ccw_q         <= 1'b0;
         jump_q        <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         hold_q        <= hold_d;
         cnt_q         <= cnt_d;
         sym_q         <= sym_d;
         dp_q          <= dp_d;
         sym_valid_q   <= sym_valid_d;
         active_q      <= active_d;
         mask_q        <= mask_d;
         frame_valid_q <= frame_valid_d;
         pos_q         <= pos_d;
         pos_valid_q   <= pos_valid_d;
         prev_valid_q  <= prev_valid_d;
         cw_q          <= cw_d;
         ccw_q         <= ccw_d;
         jump_q        <= jump_d;
         err_q         <= err_d;
      end
   end

   assign sym          = sym_q;
   assign dp           = dp_q;
   assign sym_valid    = sym_valid_q;
   assign active_digit = active_q;
   assign frame_valid  = frame_valid_q;
   assign pos          = pos_q;
   assign pos_valid    = pos_valid_q;
   assign cw_step      = cw_q;
   assign ccw_step     = ccw_q;
   assign jump         = jump_q;
   assign err          = err_q;

endmodule
`default_nettype wire
